// File: rtl/fpu_seq_ctrl.sv
// fpu_seq_ctrl: issue, latency sequencing, hazard stall and writeback arbitration for a non-pipelined FPU.
module fpu_seq_ctrl #(
   parameter int LAT_ADD = 3,
   parameter int LAT_MUL = 4,
   parameter int LAT_DIV = 12
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       id_valid,
   input  logic       id_is_fpu,
   input  logic [2:0] id_op,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic [4:0] id_rd,
   input  logic       id_rs1_f,
   input  logic       id_rs2_f,
   input  logic       id_rd_f,
   input  logic       flush,
   input  logic       int_wb_req,
   output logic       stall,
   output logic       fpu_start,
   output logic [2:0] fpu_op,
   output logic       wb_f_en,
   output logic       wb_i_en,
   output logic [4:0] wb_addr,
   output logic       busy
);
   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
   state_t state, state_n;
   logic [4:0] cnt, cnt_n, prd, lat_m1;
   logic       prd_f, issue, hazard, reg_live, src_hit, waw_hit, retire;
   always_comb begin
      lat_m1   = id_op[2] ? 5'd0 : id_op[1] ? (id_op[0] ? 5'(LAT_DIV - 1) : 5'(LAT_MUL - 1)) : 5'(LAT_ADD - 1);
      reg_live = prd_f | (prd != 5'd0);
      src_hit  = (id_rs1 == prd && id_rs1_f == prd_f) | (id_rs2 == prd && id_rs2_f == prd_f);
      waw_hit  = id_rd == prd && id_rd_f == prd_f;
      hazard   = (state != IDLE) & (id_is_fpu | (reg_live & (src_hit | waw_hit)));
      stall    = rst & id_valid & ~flush & hazard;
      issue    = rst & (state == IDLE) & id_valid & id_is_fpu & ~flush;
      fpu_start = issue;
      wb_f_en  = rst & (state == DONE) & prd_f;
      wb_i_en  = rst & (state == DONE) & ~prd_f & (prd != 5'd0) & ~int_wb_req;
      wb_addr  = (wb_f_en | wb_i_en) ? prd : 5'd0;
      busy     = state != IDLE;
      // an integer result waits while the integer pipeline owns the WB port
      retire   = prd_f | (prd == 5'd0) | ~int_wb_req;
   end
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      case (state)
         IDLE: if (issue) begin
            state_n = (lat_m1 == 5'd0) ? DONE : EXEC;
            cnt_n   = lat_m1;
         end
         EXEC: begin
            state_n = (cnt <= 5'd1) ? DONE : EXEC;
            cnt_n   = (cnt <= 5'd1) ? 5'd0 : cnt - 5'd1;
         end
         DONE: state_n = retire ? IDLE : DONE;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= IDLE;
         cnt    <= 5'd0;
         fpu_op <= 3'd0;
         prd    <= 5'd0;
         prd_f  <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (issue) begin
            fpu_op <= id_op;
            prd    <= id_rd;
            prd_f  <= id_rd_f;
         end
      end
   end
endmodule

// File: tb/tb_fpu_seq_ctrl.sv
// tb_fpu_seq_ctrl: directed plan scenarios plus random traffic checked against an age-based behavioural model.
module tb_fpu_seq_ctrl;
   logic clk = 0, rst = 0;
   logic id_valid = 0, id_is_fpu = 0, id_rs1_f = 0, id_rs2_f = 0, id_rd_f = 0, flush = 0, int_wb_req = 0;
   logic [2:0] id_op = 0;
   logic [4:0] id_rs1 = 0, id_rs2 = 0, id_rd = 0;
   logic stall, fpu_start, wb_f_en, wb_i_en, busy;
   logic [2:0] fpu_op;
   logic [4:0] wb_addr;
   int n_chk = 0, n_fail = 0;
   // model: one in-flight op described by its age since issue and its latency
   bit m_infl = 0, m_prdf = 0;
   int m_age = 0, m_lat = 0, m_prd = 0, m_op = 0;

   fpu_seq_ctrl dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_is_fpu(id_is_fpu), .id_op(id_op),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rs1_f(id_rs1_f), .id_rs2_f(id_rs2_f),
      .id_rd_f(id_rd_f), .flush(flush), .int_wb_req(int_wb_req), .stall(stall), .fpu_start(fpu_start),
      .fpu_op(fpu_op), .wb_f_en(wb_f_en), .wb_i_en(wb_i_en), .wb_addr(wb_addr), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic int lat_of(int op);
      return (op >= 4) ? 1 : (op == 3) ? 12 : (op == 2) ? 4 : 3;
   endfunction

   task automatic chk(string name, int act, int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic compare();
      bit at_done, hz, e_stall, e_start, e_wbf, e_wbi;
      at_done = m_infl && m_age >= m_lat;
      hz = m_infl && (id_is_fpu || ((m_prdf || m_prd != 0) &&
           ((id_rs1 == m_prd && id_rs1_f == m_prdf) || (id_rs2 == m_prd && id_rs2_f == m_prdf) ||
            (id_rd == m_prd && id_rd_f == m_prdf))));
      e_stall = rst && id_valid && !flush && hz;
      e_start = rst && !m_infl && id_valid && id_is_fpu && !flush;
      e_wbf = rst && at_done && m_prdf;
      e_wbi = rst && at_done && !m_prdf && m_prd != 0 && !int_wb_req;
      chk("stall", int'(stall), int'(e_stall));
      chk("fpu_start", int'(fpu_start), int'(e_start));
      chk("wb_f_en", int'(wb_f_en), int'(e_wbf));
      chk("wb_i_en", int'(wb_i_en), int'(e_wbi));
      chk("wb_addr", int'(wb_addr), (e_wbf || e_wbi) ? m_prd : 0);
      chk("busy", int'(busy), int'(m_infl));
      chk("fpu_op", int'(fpu_op), m_op);
   endtask

   task automatic model_edge();
      bit st;
      st = rst && !m_infl && id_valid && id_is_fpu && !flush;
      if (!rst) begin
         m_infl = 0; m_op = 0; m_prd = 0; m_prdf = 0;
      end else begin
         if (m_infl && m_age >= m_lat && (m_prdf || m_prd == 0 || !int_wb_req)) m_infl = 0;
         else if (m_infl) m_age++;
         if (st) begin
            m_infl = 1; m_age = 1; m_lat = lat_of(int'(id_op));
            m_prd = int'(id_rd); m_prdf = id_rd_f; m_op = int'(id_op);
         end
      end
   endtask

   task automatic sample(); @(negedge clk); compare(); endtask
   task automatic adv(); @(posedge clk); model_edge(); #1; endtask
   task automatic cyc(); sample(); adv(); endtask
   task automatic drain(int n); id_valid = 0; flush = 0; int_wb_req = 0; repeat (n) cyc(); endtask

   task automatic set_id(bit v, bit f, logic [2:0] op, logic [4:0] rs1, bit rs1f, logic [4:0] rd, bit rdf);
      id_valid = v; id_is_fpu = f; id_op = op; id_rs1 = rs1; id_rs1_f = rs1f;
      id_rs2 = 0; id_rs2_f = 0; id_rd = rd; id_rd_f = rdf;
   endtask

   task automatic issue(logic [2:0] op, logic [4:0] rd, bit rdf);
      set_id(1, 1, op, 0, 0, rd, rdf); flush = 0;
      sample(); chk("issue_start", int'(fpu_start), 1); adv();
   endtask

   initial begin
      // 1: reset gating, then add f5
      set_id(1, 1, 0, 0, 0, 5, 1);
      repeat (2) begin
         sample();
         chk("rst_start", int'(fpu_start), 0); chk("rst_stall", int'(stall), 0);
         chk("rst_busy", int'(busy), 0); chk("rst_wbf", int'(wb_f_en), 0);
         adv();
      end
      rst = 1;
      issue(0, 5, 1);
      id_valid = 0;
      repeat (2) cyc();
      sample(); chk("add_wbf", int'(wb_f_en), 1); chk("add_addr", int'(wb_addr), 5); adv();
      sample(); chk("add_busy", int'(busy), 0); adv();
      // 2: div f2 with dependent integer reader
      issue(3, 2, 1);
      set_id(1, 0, 0, 2, 1, 9, 0);
      for (int c = 1; c <= 12; c++) begin sample(); chk("div_raw_stall", int'(stall), 1); adv(); end
      sample(); chk("div_raw_clear", int'(stall), 0); adv();
      drain(2);
      issue(3, 2, 1);
      set_id(1, 0, 0, 2, 0, 9, 0);
      sample(); chk("div_xreg_nostall", int'(stall), 0); adv();
      drain(14);
      // 3: back-to-back mul f1, add f3
      issue(2, 1, 1);
      set_id(1, 1, 0, 0, 0, 3, 1);
      for (int c = 1; c <= 4; c++) begin
         sample(); chk("b2b_stall", int'(stall), 1); chk("b2b_nostart", int'(fpu_start), 0); adv();
      end
      sample(); chk("b2b_start", int'(fpu_start), 1); adv();
      drain(6);
      // 4: compare to x7 with int port contention, then rd = x0
      issue(4, 7, 0);
      id_valid = 0; int_wb_req = 1;
      repeat (2) begin sample(); chk("cmp_hold", int'(wb_i_en), 0); chk("cmp_busy", int'(busy), 1); adv(); end
      int_wb_req = 0;
      sample(); chk("cmp_wbi", int'(wb_i_en), 1); chk("cmp_addr", int'(wb_addr), 7); adv();
      sample(); chk("cmp_idle", int'(busy), 0); adv();
      issue(5, 0, 0);
      id_valid = 0;
      sample(); chk("x0_wbi", int'(wb_i_en), 0); chk("x0_wbf", int'(wb_f_en), 0); adv();
      sample(); chk("x0_idle", int'(busy), 0); adv();
      // 5: flush kills decode only
      set_id(1, 1, 2, 0, 0, 4, 1); flush = 1;
      sample(); chk("flush_nostart", int'(fpu_start), 0); chk("flush_nostall", int'(stall), 0); adv();
      issue(2, 4, 1);
      set_id(1, 1, 0, 4, 1, 4, 1); flush = 1;
      repeat (2) begin sample(); chk("flush_exec_nostall", int'(stall), 0); adv(); end
      flush = 0; id_valid = 0;
      cyc();
      sample(); chk("flush_wbf", int'(wb_f_en), 1); chk("flush_addr", int'(wb_addr), 4); adv();
      drain(2);
      // 6: reset abandons an in-flight div
      issue(3, 6, 1);
      id_valid = 0;
      repeat (2) cyc();
      rst = 0; cyc(); rst = 1;
      sample(); chk("abort_busy", int'(busy), 0); chk("abort_stall", int'(stall), 0); adv();
      drain(15);
      // random traffic
      for (int i = 0; i < 4000; i++) begin
         rst = ($urandom_range(0, 199) != 0);
         id_valid = ($urandom_range(0, 9) < 7);
         id_is_fpu = ($urandom_range(0, 9) < 4);
         id_op = 3'($urandom_range(0, 7));
         id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3)); id_rd = 5'($urandom_range(0, 3));
         id_rs1_f = 1'($urandom); id_rs2_f = 1'($urandom); id_rd_f = 1'($urandom);
         flush = ($urandom_range(0, 9) == 0);
         int_wb_req = ($urandom_range(0, 9) < 4);
         cyc();
      end
      rst = 1;
      drain(20);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
